// File: rtl/sobel_pkg.sv
// Shared widths and default frame/threshold constants for the Sobel gradient stage.
package sobel_pkg;

  localparam int PIX_W  = 8;
  localparam int GRAD_W = 11;
  localparam int MAG_W  = 10;
  localparam int CNT_W  = 16;

  localparam int ROWS_DEF   = 128;
  localparam int COLS_DEF   = 128;
  localparam int THRESH_DEF = 100;

  localparam logic [PIX_W-1:0] PIX_MAX = 8'd255;

endpackage

// File: rtl/sobel_abs.sv
// Registered absolute value of a signed gradient; |-1020| fits MAG_W, so no overflow case.
module sobel_abs
  import sobel_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [GRAD_W-1:0] grad_i,
  output logic        [MAG_W-1:0]  mag_o
);

  logic [MAG_W-1:0] mag_d;
  logic [MAG_W-1:0] mag_q;

  // Two's-complement negate on the low bits only; the sign bit never survives into the result.
  always_comb begin
    mag_d = grad_i[MAG_W-1:0];
    if (grad_i[GRAD_W-1]) begin
      mag_d = ~grad_i[MAG_W-1:0] + MAG_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mag_q <= '0;
    end else begin
      mag_q <= mag_d;
    end
  end

  assign mag_o = mag_q;

endmodule

// File: rtl/sobel_gradient_calc.sv
// 3-stage Sobel gradient: S1 Gx/Gy, S2 abs, S3 saturated L1 magnitude + edge flag, with frame counting.
module sobel_gradient_calc
  import sobel_pkg::*;
#(
  parameter int ROWS   = ROWS_DEF,
  parameter int COLS   = COLS_DEF,
  parameter int THRESH = THRESH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] d0_i,
  input  logic [PIX_W-1:0] d1_i,
  input  logic [PIX_W-1:0] d2_i,
  input  logic [PIX_W-1:0] d3_i,
  input  logic [PIX_W-1:0] d4_i,
  input  logic [PIX_W-1:0] d5_i,
  input  logic [PIX_W-1:0] d6_i,
  input  logic [PIX_W-1:0] d7_i,
  input  logic [PIX_W-1:0] d8_i,
  input  logic             valid_i,
  output logic [PIX_W-1:0] pix_o,
  output logic             edge_o,
  output logic             valid_o,
  output logic             frame_done_o
);

  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(ROWS * COLS - 1);
  localparam logic [PIX_W-1:0] THR      = PIX_W'(THRESH);

  logic [MAG_W-1:0]         xp_sum, xn_sum, yp_sum, yn_sum;
  logic signed [GRAD_W-1:0] gx_d, gy_d, gx_q, gy_q;
  logic [MAG_W-1:0]         ax, ay;
  logic [GRAD_W-1:0]        sum;
  logic [PIX_W-1:0]         pix_d, pix_q;
  logic                     edge_d, edge_q;
  logic                     v1_q, v2_q, v3_q;
  logic [CNT_W-1:0]         cnt_d, cnt_q;
  logic                     fd_d, fd_q;
  logic                     unused_d4;

  // The centre tap has zero weight in both kernels.
  assign unused_d4 = ^d4_i;

  always_comb begin
    xp_sum = {2'b00, d2_i} + {1'b0, d5_i, 1'b0} + {2'b00, d8_i};
    xn_sum = {2'b00, d0_i} + {1'b0, d3_i, 1'b0} + {2'b00, d6_i};
    yp_sum = {2'b00, d6_i} + {1'b0, d7_i, 1'b0} + {2'b00, d8_i};
    yn_sum = {2'b00, d0_i} + {1'b0, d1_i, 1'b0} + {2'b00, d2_i};
    gx_d   = $signed({1'b0, xp_sum}) - $signed({1'b0, xn_sum});
    gy_d   = $signed({1'b0, yp_sum}) - $signed({1'b0, yn_sum});
  end

  sobel_abs u_abs_x (.clk(clk), .rst(rst), .grad_i(gx_q), .mag_o(ax));
  sobel_abs u_abs_y (.clk(clk), .rst(rst), .grad_i(gy_q), .mag_o(ay));

  always_comb begin
    sum    = {1'b0, ax} + {1'b0, ay};
    pix_d  = (|sum[GRAD_W-1:PIX_W]) ? PIX_MAX : sum[PIX_W-1:0];
    edge_d = (pix_d >= THR);
  end

  // Count is taken as the result enters S3 so frame_done lands on the same cycle as valid_o.
  always_comb begin
    cnt_d = cnt_q;
    fd_d  = 1'b0;
    if (v2_q) begin
      if (cnt_q == LAST_PIX) begin
        cnt_d = '0;
        fd_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gx_q   <= '0;
      gy_q   <= '0;
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      pix_q  <= '0;
      edge_q <= 1'b0;
      cnt_q  <= '0;
      fd_q   <= 1'b0;
    end else begin
      gx_q <= gx_d;
      gy_q <= gy_d;
      v1_q <= valid_i;
      v2_q <= v1_q;
      v3_q <= v2_q;
      if (v2_q) begin
        pix_q  <= pix_d;
        edge_q <= edge_d;
      end
      cnt_q <= cnt_d;
      fd_q  <= fd_d;
    end
  end

  assign pix_o        = pix_q;
  assign edge_o       = edge_q;
  assign valid_o      = v3_q;
  assign frame_done_o = fd_q;

endmodule

// File: tb/tb_sobel_gradient_calc.sv
// Scoreboard bench for sobel_gradient_calc: driver pushes model results, negedge monitor pops and compares.
module tb_sobel_gradient_calc;

  localparam int ROWS   = 5;
  localparam int COLS   = 6;
  localparam int THRESH = 100;
  localparam int FRAME  = ROWS * COLS;
  localparam int LAT    = 3;

  typedef struct {
    int pix;
    bit edg;
    bit fd;
    int due;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] d [9];
  logic       valid_i;
  logic [7:0] pix_o;
  logic       edge_o, valid_o, frame_done_o;

  exp_t sbq[$];
  int   win[9];
  int   cyc = 0;
  int   issued = 0;
  int   checks = 0;
  int   fails = 0;
  int   fd_cnt = 0;
  int   last_pix = 0;
  bit   last_edge = 1'b0;
  bit   mon_en = 1'b0;
  bit   done = 1'b0;

  sobel_gradient_calc #(.ROWS(ROWS), .COLS(COLS), .THRESH(THRESH)) dut (
    .clk(clk), .rst(rst),
    .d0_i(d[0]), .d1_i(d[1]), .d2_i(d[2]), .d3_i(d[3]), .d4_i(d[4]),
    .d5_i(d[5]), .d6_i(d[6]), .d7_i(d[7]), .d8_i(d[8]),
    .valid_i(valid_i), .pix_o(pix_o), .edge_o(edge_o),
    .valid_o(valid_o), .frame_done_o(frame_done_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Reference model: Sobel kernels evaluated directly with integer arithmetic.
  task automatic issue();
    int gx, gy, mag;
    exp_t e;
    gx  = (win[2] + 2 * win[5] + win[8]) - (win[0] + 2 * win[3] + win[6]);
    gy  = (win[6] + 2 * win[7] + win[8]) - (win[0] + 2 * win[1] + win[2]);
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    if (mag > 255) mag = 255;
    e.pix = mag;
    e.edg = (mag >= THRESH);
    e.fd  = ((issued % FRAME) == FRAME - 1);
    e.due = cyc + LAT;
    issued++;
    sbq.push_back(e);
    for (int k = 0; k < 9; k++) d[k] = 8'(win[k]);
    valid_i = 1'b1;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    valid_i = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_win();
    for (int k = 0; k < 9; k++) win[k] = 0;
  endtask

  task automatic rand_win();
    int mode;
    mode = $urandom_range(0, 2);
    for (int k = 0; k < 9; k++) begin
      if (mode == 0) win[k] = $urandom_range(0, 255);
      else if (mode == 1) win[k] = $urandom_range(0, 15);
      else win[k] = 120 + $urandom_range(0, 10);
    end
  endtask

  task automatic do_reset(input int n);
    valid_i = 1'b0;
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    issued = 0;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(clk) begin
    exp_t e;
    if (clk) begin
      if (rst) begin
        sbq.delete();
        last_pix  = 0;
        last_edge = 1'b0;
      end
    end else if (mon_en) begin
      if (valid_o) begin
        if (sbq.size() == 0) begin
          chk("unexpected_valid_o", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("latency_cycle", cyc, e.due);
          chk("pix_o", int'(pix_o), e.pix);
          chk("edge_o", int'(edge_o), int'(e.edg));
          chk("frame_done_o", int'(frame_done_o), int'(e.fd));
          last_pix  = e.pix;
          last_edge = e.edg;
        end
      end else begin
        chk("frame_done_idle", int'(frame_done_o), 0);
        chk("pix_hold", int'(pix_o), last_pix);
        chk("edge_hold", int'(edge_o), int'(last_edge));
      end
      if (frame_done_o) fd_cnt++;
      if (done) begin
        chk("scoreboard_drained", sbq.size(), 0);
        chk("frame_done_total", fd_cnt, 3);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
      end
    end
  end

  initial begin
    valid_i = 1'b0;
    rst = 1'b1;
    for (int k = 0; k < 9; k++) d[k] = 8'd0;
    do_reset(3);
    mon_en = 1'b1;
    idle(2);

    clear_win();
    issue();
    idle(4);
    clear_win(); win[5] = 10;
    issue();
    clear_win(); win[3] = 50;
    issue();
    clear_win(); win[3] = 49;
    issue();
    clear_win();
    win[2] = 255; win[5] = 255; win[8] = 255; win[6] = 255; win[7] = 255;
    issue();
    idle(5);

    do_reset(1);
    idle(2);
    for (int i = 0; i < 2 * FRAME; i++) begin
      rand_win();
      issue();
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    rand_win(); issue();
    rand_win(); issue();
    do_reset(1);
    idle(6);

    for (int i = 0; i < FRAME; i++) begin
      rand_win();
      issue();
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
    end
    idle(8);
    done = 1'b1;
  end

endmodule
